// File: rtl/para_pkg.sv
// Shared types for the tensor-core operand fetch sequencer: precision,
// address-generator reset controls, scheduler states and lanes-per-word ratio.
package params;

  typedef enum logic [1:0] {
    PREC_FP32 = 2'd0,
    PREC_FP16 = 2'd1,
    PREC_INT8 = 2'd2,
    PREC_INT4 = 2'd3
  } prec_t;

  typedef struct packed {
    logic resetA;
    logic resetB;
  } addrgen_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sched_state_t;

  // Packed lanes per operand word; the address advances once per this many beats.
  function automatic logic [3:0] prec_ratio(input prec_t p);
    case (p)
      PREC_FP32: return 4'd1;
      PREC_FP16: return 4'd2;
      PREC_INT8: return 4'd4;
      default:   return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/fetch_pace_cnt.sv
// Packed-lane (sub_idx) counter: wraps at ratio-1, holds while not advancing,
// and strobes word_adv on the wrap beat so the word addresses step.
module fetch_pace_cnt
  import params::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       adv_i,
  input  prec_t      prec_i,
  output logic [2:0] sub_idx_o,
  output logic       word_adv_o
);

  logic [2:0] sub_q, sub_d, last_sub;

  assign last_sub   = 3'(prec_ratio(prec_i) - 4'd1);
  assign word_adv_o = adv_i && (sub_q == last_sub);
  assign sub_idx_o  = sub_q;

  always_comb begin
    sub_d = sub_q;
    if (clr_i || word_adv_o) sub_d = '0;
    else if (adv_i)          sub_d = sub_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sub_q <= '0;
    else      sub_q <= sub_d;
  end

endmodule

// File: rtl/operand_fetch_sched.sv
// Operand fetch sequencer: walks the A/B buffer read addresses for one tile,
// pacing word advance by precision, then drains the SRAM pipe and pulses done.
module operand_fetch_sched
  import params::*;
#(
  parameter int ADDR_W   = 4,
  parameter int SRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  prec_t             prec,
  input  logic [ADDR_W-1:0] k_len,
  input  logic              stall,
  output logic              en_out,
  output addrgen_t          addrs,
  output logic [ADDR_W-1:0] a_rdaddr,
  output logic [ADDR_W-1:0] b_rdaddr,
  output logic [2:0]        sub_idx,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] DRAIN_INIT = 2'(SRAM_LAT - 1);

  sched_state_t      state_q;
  prec_t             prec_q;
  logic [ADDR_W-1:0] klen_q, addr_q;
  logic [1:0]        drain_q;
  addrgen_t          addrs_q;
  logic              en_base_q, run_q, busy_q, done_q;

  logic word_adv, last_beat, pace_adv, pace_clr, abort_ok;

  // Abort wins over stall and last-beat completion, so it also gates the pacer.
  assign abort_ok  = abort && (state_q == S_LOAD || state_q == S_RUN || state_q == S_DRAIN);
  assign pace_adv  = run_q && !stall && !abort;
  assign pace_clr  = !run_q || abort;
  assign last_beat = word_adv && (addr_q == klen_q);

  fetch_pace_cnt u_pace (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (pace_clr),
    .adv_i      (pace_adv),
    .prec_i     (prec_q),
    .sub_idx_o  (sub_idx),
    .word_adv_o (word_adv)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      prec_q    <= PREC_FP32;
      klen_q    <= '0;
      addr_q    <= '0;
      drain_q   <= '0;
      addrs_q   <= '0;
      en_base_q <= 1'b0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addrs_q   <= '0;
      en_base_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort_ok) begin
        // One-cycle flush in IDLE: re-arm the address generators, no done.
        state_q   <= S_IDLE;
        addrs_q   <= addrgen_t'(2'b11);
        en_base_q <= 1'b1;
        run_q     <= 1'b0;
        busy_q    <= 1'b0;
        addr_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            state_q   <= S_LOAD;
            prec_q    <= prec;
            klen_q    <= k_len;
            addr_q    <= '0;
            addrs_q   <= addrgen_t'(2'b11);
            en_base_q <= 1'b1;
            busy_q    <= 1'b1;
          end
          S_LOAD: begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
          end
          S_RUN: begin
            if (last_beat) begin
              state_q <= S_DRAIN;
              run_q   <= 1'b0;
              drain_q <= DRAIN_INIT;
            end else if (word_adv) begin
              addr_q  <= addr_q + 1'b1;
            end
          end
          S_DRAIN: begin
            if (drain_q == 2'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              drain_q <= drain_q - 2'd1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            addr_q  <= '0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Stall suppresses issue in the same cycle it is seen.
  assign rd_valid = run_q && !stall;
  assign en_out   = en_base_q || rd_valid;
  assign addrs    = addrs_q;
  assign a_rdaddr = addr_q;
  assign b_rdaddr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_operand_fetch_sched.sv
// Directed bench for operand_fetch_sched: beat/address sequences per precision,
// stall hold, abort flush, start-while-busy and async reset.
module tb_operand_fetch_sched;
  import params::*;

  logic       clk = 1'b0;
  logic       rst, start, abort, stall;
  prec_t      prec;
  logic [3:0] k_len;
  logic       en_out, rd_valid, busy, done;
  addrgen_t   addrs;
  logic [3:0] a_rdaddr, b_rdaddr;
  logic [2:0] sub_idx;
  int         total = 0;
  int         bad = 0;

  operand_fetch_sched #(.ADDR_W(4), .SRAM_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .prec(prec),
    .k_len(k_len), .stall(stall), .en_out(en_out), .addrs(addrs),
    .a_rdaddr(a_rdaddr), .b_rdaddr(b_rdaddr), .sub_idx(sub_idx),
    .rd_valid(rd_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [5:0] flg = {en_out, addrs, rd_valid, busy, done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Start a tile at the current cycle (cycle 0) and follow it to done.
  task automatic tile(input int p, input int k, input int st_beat, input int st_len,
                      input bit glitch, input int exp_done);
    int ratio, total_b, beats, stalled;
    bit seen;
    ratio = 1 << p; total_b = (k + 1) * ratio;
    beats = 0; stalled = 0; seen = 0;
    start = 1'b1; prec = prec_t'(p); k_len = 4'(k);
    cyc();
    start = 1'b0;
    #1;
    chk("load_flags", flg, 6'b1_11_0_1_0);
    chk("load_addr", {a_rdaddr, b_rdaddr, sub_idx}, 0);
    for (int n = 2; n < 64 && !seen; n++) begin
      cyc();
      stall = (beats == st_beat) && (stalled < st_len);
      if (glitch && beats == 1) begin
        start = 1'b1; prec = PREC_INT4; k_len = 4'd15;
      end else start = 1'b0;
      #1;
      if (done) begin
        seen = 1;
        chk("done_cyc", n, exp_done);
        chk("done_beats", beats, total_b);
      end else if (stall) begin
        chk("stall_flags", {en_out, rd_valid}, 0);
        chk("stall_addr", a_rdaddr, beats / ratio);
        chk("stall_sub", sub_idx, beats % ratio);
        stalled++;
      end else if (beats < total_b) begin
        chk("beat_vld", {en_out, rd_valid, busy}, 3'b111);
        chk("beat_a", a_rdaddr, beats / ratio);
        chk("beat_b", b_rdaddr, beats / ratio);
        chk("beat_sub", sub_idx, beats % ratio);
        beats++;
      end else begin
        chk("drain_flags", flg, 6'b0_00_0_1_0);
      end
    end
    stall = 1'b0; start = 1'b0;
    chk("done_seen", seen, 1);
    cyc();
    #1;
    chk("idle_after", flg, 0);
    chk("idle_addr", {a_rdaddr, sub_idx}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    start = 0; abort = 0; stall = 0; prec = PREC_FP32; k_len = 0;
    rst = 1'b1;
    #3 rst = 1'b0;
    #2;
    chk("rst_flags", flg, 0);
    chk("rst_addr", {a_rdaddr, b_rdaddr, sub_idx}, 0);
    repeat (2) cyc();
    rst = 1'b1;

    tile(0, 3, -1, 0, 0, 7);   // FP32: beats 2..5, done@7
    tile(3, 1, -1, 0, 0, 19);  // INT4: 16 beats
    tile(1, 2, 3, 2, 0, 11);   // FP16 stall at (1,1) for 2 cycles
    tile(0, 15, -1, 0, 1, 19); // k_len=15 with start glitch in RUN

    // INT8 abort on the 5th beat
    start = 1'b1; prec = PREC_INT8; k_len = 4'd2;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("ab_pre_vld", rd_valid, 1);
    end
    cyc();
    abort = 1'b1;
    #1;
    chk("ab_beat5", {a_rdaddr, 1'b0, sub_idx}, {4'd1, 1'b0, 3'd0});
    cyc();
    abort = 1'b0;
    #1;
    chk("ab_flush", flg, 6'b1_11_0_0_0);
    chk("ab_addr", a_rdaddr, 0);
    cyc(); #1;
    chk("ab_after", flg, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("ab_nodone", {busy, done}, 0);
    end
    tile(0, 0, -1, 0, 0, 4);   // restart from address 0, done@N+4

    // abort in IDLE ignored; start+abort in IDLE: start wins, held abort kills LOAD
    abort = 1'b1;
    cyc(); #1;
    chk("idle_abort", flg, 0);
    start = 1'b1; prec = PREC_FP16; k_len = 4'd1;
    cyc();
    start = 1'b0;
    #1;
    chk("sa_load", flg, 6'b1_11_0_1_0);
    cyc();
    abort = 1'b0;
    #1;
    chk("load_abort", flg, 6'b1_11_0_0_0);
    cyc(); #1;
    chk("load_abort_after", flg, 0);

    // async reset mid-RUN
    start = 1'b1; prec = PREC_FP32; k_len = 4'd5;
    cyc();
    start = 1'b0;
    cyc(); cyc(); #1;
    chk("arst_pre", {rd_valid, a_rdaddr}, {1'b1, 4'd1});
    rst = 1'b0;
    #1;
    chk("arst_flags", flg, 0);
    chk("arst_addr", {a_rdaddr, b_rdaddr, sub_idx}, 0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      chk("arst_quiet", flg, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
